// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_e : receiver FSM state encoding
//   DATA_W     : payload width in bits
//   majority3  : 2-of-3 vote used to resolve each sampled bit
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioner for the asynchronous serial line.
// Two-flop synchroniser followed by a one-flop history used for falling-edge
// detection. All flops reset to 1 so that reset never looks like a start edge.
//   clk    : receiver clock
//   rst    : asynchronous active-high reset
//   rx_i   : raw asynchronous serial line
//   rx_s_o : synchronised line level
//   fall_o : one-cycle flag, rx_s went 1 -> 0 this cycle
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour (a true shift chain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8 data bits, LSB first, idle-high line).
// Each bit is resolved by a 3-sample majority vote around the bit centre.
// Optional even parity between data and stop bits: define UART_RX_PARITY_EN.
//   Parameters: OVERSAMPLE (8..64) clk cycles per bit, STOP (1 or 2) stop bits.
//   clk       : receiver clock, OVERSAMPLE x baud
//   rst       : asynchronous active-high reset
//   rx        : asynchronous serial line
//   data      : last good byte, held until the next good frame
//   valid     : one-cycle pulse, data updated this cycle
//   frame_err : one-cycle pulse, bad stop (or parity) bit, data unchanged
//   busy      : high while a frame is in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int STOP       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);

    // Sample points: one either side of the centre plus the centre itself.
    localparam logic [TICK_W-1:0] T_S0  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] T_S1  = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] T_RES = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] T_END = TICK_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    rx_state_e         state_q;
    logic [TICK_W-1:0] tick_q;
    logic [2:0]        bit_cnt_q;
    logic              stop_cnt_q;
    logic [1:0]        samp_q;
    logic [DATA_W-1:0] shift_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ferr_q;

    // Third sample is the live line value at the resolve tick.
    logic bit_maj;
    assign bit_maj = majority3(samp_q[0], samp_q[1], rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; a later assignment in the
            // same block overrides it, so they stay high for exactly one cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            if (tick_q == T_S0) samp_q[0] <= rx_s;
            if (tick_q == T_S1) samp_q[1] <= rx_s;

            unique case (state_q)
                ST_IDLE: begin
                    tick_q <= '0;
                    if (fall) state_q <= ST_START;
                end

                ST_START: begin
                    if (tick_q == T_RES && bit_maj) begin
                        // Start bit did not hold low through its centre: glitch.
                        state_q <= ST_IDLE;
                        tick_q  <= '0;
                    end else if (tick_q == T_END) begin
                        state_q   <= ST_DATA;
                        tick_q    <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                ST_DATA: begin
                    if (tick_q == T_RES) shift_q <= {bit_maj, shift_q[DATA_W-1:1]};
                    if (tick_q == T_END) begin
                        tick_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q    <= AFTER_DATA;
                            stop_cnt_q <= 1'b0;
                            err_q      <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    if (tick_q == T_RES) err_q <= (^shift_q) ^ bit_maj;
                    if (tick_q == T_END) begin
                        state_q <= ST_STOP;
                        tick_q  <= '0;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (tick_q == T_RES && stop_cnt_q == 1'(STOP - 1)) begin
                        // Leave mid-bit so the next start edge is never missed.
                        state_q <= ST_IDLE;
                        tick_q  <= '0;
                        if (err_q || !bit_maj) begin
                            ferr_q <= 1'b1;
                        end else begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else if (tick_q == T_RES) begin
                        err_q  <= err_q | ~bit_maj;
                        tick_q <= tick_q + TICK_W'(1);
                    end else if (tick_q == T_END) begin
                        tick_q     <= '0;
                        stop_cnt_q <= 1'b1;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tick_q  <= '0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
